// File: rtl/enc_pkg.sv
// ----------------------------------------------------------------------------
// enc_pkg
//   Shared definitions for the instruction encoder. The instruction field
//   widths and bit positions are also used by the fetch decoder. The package
//   provides the decoded-field struct, the encoder state and error-code enums,
//   and the function that packs fields into an instruction word.
// ----------------------------------------------------------------------------
package enc_pkg;

    localparam int INSTR_W   = 32;
    localparam int OP_W      = 4;
    localparam int REG_W     = 3;
    localparam int IMM_W     = 17;
    localparam int IMM_ENC_W = 16;

    localparam int OP_LSB    = 28;
    localparam int COND_BIT  = 27;
    localparam int RVD_BIT   = 26;
    localparam int RVS_BIT   = 25;
    localparam int RND_LSB   = 22;
    localparam int RNSA_LSB  = 19;
    localparam int RNSB_LSB  = 16;
    localparam int IMM_LSB   = 0;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic             cond;
        logic             rvd;
        logic             rvs;
        logic [REG_W-1:0] rnd;
        logic [REG_W-1:0] rnsa;
        logic [REG_W-1:0] rnsb;
        logic [IMM_W-1:0] imm;
    } instr_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ERR  = 2'd2
    } enc_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_CONFLICT = 2'b01,
        ERR_OVERFLOW = 2'b10
    } enc_err_e;

    // Bit 16 belongs to rnsb[0]; imm[16] has no slot in the word.
    function automatic logic [INSTR_W-1:0] pack_fields(input instr_fields_t f);
        logic [INSTR_W-1:0] w;
        w = {INSTR_W{1'b0}};
        w[OP_LSB +: OP_W]         = f.op;
        w[COND_BIT]               = f.cond;
        w[RVD_BIT]                = f.rvd;
        w[RVS_BIT]                = f.rvs;
        w[RND_LSB +: REG_W]       = f.rnd;
        w[RNSA_LSB +: REG_W]      = f.rnsa;
        w[RNSB_LSB +: REG_W]      = f.rnsb;
        w[IMM_LSB +: IMM_ENC_W]   = f.imm[IMM_ENC_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// ----------------------------------------------------------------------------
// enc_fifo
//   Synchronous FIFO holding packed instruction words between the field
//   stream and the instruction-memory write port.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of all entries
//   push, din       write one entry (ignored when full)
//   pop             remove head entry (ignored when empty)
//   dout            head entry
//   full, empty     occupancy flags
//   count           number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module enc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the occupancy flags.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, cleared on reset so the head never shows stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Flag and head decode from registered state.
    always_comb begin
        dout  = mem_r[rd_ptr_r];
        full  = (count_r == CW'(DEPTH));
        empty = (count_r == {CW{1'b0}});
        count = count_r;
    end

endmodule

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Packs decoded instruction fields into 32-bit words and writes them into
//   instruction memory from base_addr upward, with a small word buffer,
//   backpressure on both sides and sticky error reporting.
// Configuration macro:
//   ENC_CHECK_EN  when defined, a beat whose imm[16] differs from rnsb[0]
//                 is rejected (not written) and the session enters ERR with
//                 err_code 01. When undefined, imm[16] is dropped silently.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, base_addr                begin a session at base_addr (IDLE/ERR only)
//   in_valid, in_ready              field-beat handshake
//   op, cond, rvd, rvs, rnd, rnsa,
//   rnsb, imm, in_last              instruction fields, end-of-program marker
//   mem_we, mem_addr, mem_wdata,
//   mem_ready                       imem write handshake
//   busy, done, err, err_code       session status
//   word_count                      words written this session
// ----------------------------------------------------------------------------
module instr_encoder
    import enc_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic              cond,
    input  logic              rvd,
    input  logic              rvs,
    input  logic [2:0]        rnd,
    input  logic [2:0]        rnsa,
    input  logic [2:0]        rnsb,
    input  logic [16:0]       imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    enc_state_e        state_r;
    enc_state_e        state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   word_count_r;
    logic              last_seen_r;
    enc_err_e          err_code_r;

    instr_fields_t     fields_s;
    logic [31:0]       word_s;
    logic              conflict_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              push_s;
    logic              mem_we_s;
    logic              pop_s;
    logic              start_ok_s;
    logic              flush_s;
    logic [CNT_W-1:0]  count_after_s;
    logic              overflow_s;
    logic              done_s;

    logic [31:0]       fifo_dout_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;

`ifdef ENC_CHECK_EN
    // Field-conflict detector: bit 16 cannot carry both rnsb[0] and imm[16].
    always_comb begin
        conflict_s = (imm[16] != rnsb[0]);
    end
`else
    logic imm_hi_unused_s;

    // imm[16] has no slot in the word and is not checked in this build.
    always_comb begin
        conflict_s      = 1'b0;
        imm_hi_unused_s = imm[16];
    end
`endif

    // Handshake, buffer control and error detection, all from registered state.
    always_comb begin
        fields_s   = {op, cond, rvd, rvs, rnd, rnsa, rnsb, imm};
        word_s     = pack_fields(fields_s);
        in_ready_s = (state_r == ST_LOAD) && !fifo_full_s && !last_seen_r;
        accept_s   = in_valid && in_ready_s;
        push_s     = accept_s && !conflict_s;
        mem_we_s   = (state_r == ST_LOAD) && !fifo_empty_s;
        pop_s      = mem_we_s && mem_ready;
        start_ok_s = start && (state_r != ST_LOAD);
        flush_s    = start_ok_s || (state_r == ST_ERR);
        // Occupancy after this cycle's push/pop decides whether work remains
        // once the last address has been written.
        count_after_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
        overflow_s    = pop_s && (addr_r == ADDR_MAX) &&
                        ((count_after_s != {CNT_W{1'b0}}) || !last_seen_r);
        done_s        = (state_r == ST_LOAD) && last_seen_r && fifo_empty_s;
    end

    // Next-state logic for the session controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s && conflict_s) begin
                    state_s = ST_ERR;
                end else if (overflow_s) begin
                    state_s = ST_ERR;
                end else if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_ERR: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Session datapath: write address, word counter, end marker, error code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r       <= {ADDR_W{1'b0}};
            word_count_r <= {(ADDR_W+1){1'b0}};
            last_seen_r  <= 1'b0;
            err_code_r   <= ERR_NONE;
        end else if (start_ok_s) begin
            addr_r       <= base_addr;
            word_count_r <= {(ADDR_W+1){1'b0}};
            last_seen_r  <= 1'b0;
            err_code_r   <= ERR_NONE;
        end else if (state_r == ST_LOAD) begin
            if (pop_s) begin
                word_count_r <= word_count_r + (ADDR_W+1)'(1);
                // The address saturates at the top of memory; overflow handles the rest.
                if (addr_r != ADDR_MAX) begin
                    addr_r <= addr_r + ADDR_W'(1);
                end
            end
            if (accept_s && in_last) begin
                last_seen_r <= 1'b1;
            end
            if (accept_s && conflict_s) begin
                err_code_r <= ERR_CONFLICT;
            end else if (overflow_s) begin
                err_code_r <= ERR_OVERFLOW;
            end
        end
    end

    enc_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_s),
        .push  (push_s),
        .din   (word_s),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Output decode; write data is forced to zero whenever no write is requested.
    always_comb begin
        in_ready   = in_ready_s;
        mem_we     = mem_we_s;
        mem_addr   = addr_r;
        mem_wdata  = mem_we_s ? fifo_dout_s : 32'h0000_0000;
        busy       = (state_r == ST_LOAD);
        done       = done_s;
        err        = (state_r == ST_ERR);
        err_code   = err_code_r;
        word_count = word_count_r;
    end

endmodule
